// File: rtl/root_seq.sv
// root_seq: operand FIFO in front of an iterative square-root unit, one operation
// in flight, a held result register towards the consumer and a launch watchdog.
module root_seq #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [15:0]                 in_data_bi,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [7:0]                  out_data_bo,
  output logic [15:0]                 out_arg_bo,
  output logic                        root_start_o,
  output logic [15:0]                 root_x_bo,
  input  logic [7:0]                  root_y_bi,
  input  logic [1:0]                  root_busy_bi,
  output logic                        err_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_e;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          in_ready_q;

  state_e        state_q;
  logic          start_q;
  logic [15:0]   x_q;
  logic [15:0]   arg_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          err_q;
  logic [CW-1:0] wd_q;

  logic          push_s;
  logic          launch_s;
  logic [15:0]   head_s;
  logic [CW-1:0] wd_inc_s;
  logic          expired_s;

  always_comb begin
    push_s    = in_valid_i & in_ready_q;
    launch_s  = (state_q == S_IDLE) && (level_q != {LW{1'b0}}) &&
                (root_busy_bi == 2'b00) && !valid_q;
    head_s    = mem_q[rd_ptr_q];
    wd_inc_s  = wd_q + CW'(1);
    expired_s = (wd_inc_s == CW'(TIMEOUT));
    if (push_s && !launch_s) begin
      level_d = level_q + LW'(1);
    end else if (!push_s && launch_s) begin
      level_d = level_q - LW'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Operand storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data_bi;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      level_q    <= {LW{1'b0}};
      in_ready_q <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (launch_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      level_q    <= level_d;
      in_ready_q <= (level_d < LW'(FIFO_DEPTH));
    end
  end

  // Launch/collect sequencer; a finished result wins over a simultaneous expiry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      x_q     <= 16'd0;
      arg_q   <= 16'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= {CW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (launch_s) begin
            x_q     <= head_s;
            arg_q   <= head_s;
            start_q <= 1'b1;
            wd_q    <= {CW{1'b0}};
            state_q <= S_LAUNCH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          start_q <= 1'b0;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          wd_q <= wd_inc_s;
          if (expired_s) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (root_busy_bi != 2'b00) begin
            state_q <= S_WAIT_DONE;
          end else begin
            state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_DONE: begin
          wd_q <= wd_inc_s;
          if (root_busy_bi == 2'b00) begin
            data_q  <= root_y_bi;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end else if (expired_s) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_HOLD: begin
          if (out_ready_i) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_HOLD;
          end
        end
        default: begin
          start_q <= 1'b0;
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign level_o      = level_q;
  assign root_start_o = start_q;
  assign root_x_bo    = x_q;
  assign out_valid_o  = valid_q;
  assign out_data_bo  = data_q;
  assign out_arg_bo   = arg_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_root_seq.sv
// Directed bench for root_seq: stub root unit, queue-based scoreboard checked every
// cycle on the falling edge, plus literal expectations from the stimulus process.
module tb_root_seq;

  localparam int DEPTH = 4;
  localparam int TOUT  = 64;
  localparam int LAT   = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] in_data_bi = 16'd0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [7:0]  out_data_bo;
  logic [15:0] out_arg_bo;
  logic        root_start_o;
  logic [15:0] root_x_bo;
  logic [7:0]  root_y_bi;
  logic [1:0]  root_busy_bi;
  logic        err_o;
  logic [2:0]  level_o;

  root_seq #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_bi(in_data_bi), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_bo(out_data_bo), .out_arg_bo(out_arg_bo), .root_start_o(root_start_o),
    .root_x_bo(root_x_bo), .root_y_bi(root_y_bi), .root_busy_bi(root_busy_bi),
    .err_o(err_o), .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  int vec = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec = vec + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] isqrt(input logic [15:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r = r + 1;
    return r[7:0];
  endfunction

  // Root unit stub: busy for LAT cycles, result visible only in its first idle cycle.
  logic       stub_stuck = 1'b0;
  logic [1:0] busy_r = 2'd0;
  logic [7:0] y_r = 8'd0;
  logic [7:0] yres_r = 8'd0;
  int         cnt_r = 0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      busy_r <= 2'd0; y_r <= 8'd0; yres_r <= 8'd0; cnt_r <= 0;
    end else if (busy_r != 2'd0) begin
      if (!stub_stuck) begin
        if (cnt_r == 1) begin
          busy_r <= 2'd0; y_r <= yres_r;
        end else begin
          cnt_r <= cnt_r - 1; busy_r <= 2'd2;
        end
      end
    end else begin
      y_r <= 8'd0;
      if (root_start_o) begin
        busy_r <= 2'd1; cnt_r <= LAT; yres_r <= isqrt(root_x_bo);
      end
    end
  end

  assign root_busy_bi = busy_r;
  assign root_y_bi    = y_r;

  // Scoreboard: operands waiting in the FIFO, and the result owed for the launched one.
  typedef struct packed { logic [15:0] a; logic [7:0] d; } res_t;
  logic [15:0] pend_q[$];
  res_t        res_q[$];
  int          level_m = 0;
  logic        err_exp = 1'b0;
  int          deadline = -1;
  logic        prev_rst = 1'b1;
  logic        push_pend = 1'b0;
  logic [15:0] push_data = 16'd0;
  logic        hold_prev = 1'b0;
  logic [7:0]  data_prev = 8'd0;
  logic [15:0] arg_prev = 16'd0;
  logic        start_prev = 1'b0;

  always @(negedge clk_i) begin
    if (prev_rst) begin
      check("reset_outputs", {in_ready_o, out_valid_o, out_data_bo, out_arg_bo,
            root_start_o, root_x_bo, err_o, level_o}, 64'd0);
      pend_q.delete(); res_q.delete();
      level_m = 0; err_exp = 1'b0; deadline = -1;
    end else begin
      if (push_pend) begin
        pend_q.push_back(push_data);
        level_m = level_m + 1;
      end
      if (root_start_o) begin
        check("start_while_busy", root_busy_bi, 2'd0);
        check("start_while_inflight", res_q.size(), 0);
        check("start_double", start_prev, 1'b0);
        check("start_has_operand", pend_q.size() > 0, 1'b1);
        if (pend_q.size() > 0) begin
          logic [15:0] x;
          x = pend_q.pop_front();
          check("root_x", root_x_bo, x);
          res_q.push_back('{a: x, d: isqrt(x)});
          level_m = level_m - 1;
        end
        if (stub_stuck) deadline = cyc + TOUT + 1;
      end
      if (cyc == deadline) begin
        err_exp = 1'b1;
        if (res_q.size() > 0) void'(res_q.pop_front());
        deadline = -1;
      end
      check("err", err_o, err_exp);
      check("level", level_o, level_m);
      check("in_ready", in_ready_o, (level_m < DEPTH) ? 1 : 0);
      if (hold_prev) begin
        check("hold_valid", out_valid_o, 1'b1);
        check("hold_data", out_data_bo, data_prev);
        check("hold_arg", out_arg_bo, arg_prev);
      end
      if (out_valid_o && out_ready_i && !rst_i) begin
        check("result_owed", res_q.size() > 0, 1'b1);
        if (res_q.size() > 0) begin
          res_t e;
          e = res_q.pop_front();
          check("out_data", out_data_bo, e.d);
          check("out_arg", out_arg_bo, e.a);
        end
      end
    end
    prev_rst   = rst_i;
    push_pend  = in_valid_i & in_ready_o & !rst_i;
    push_data  = in_data_bi;
    hold_prev  = out_valid_o & !out_ready_i & !rst_i;
    data_prev  = out_data_bo;
    arg_prev   = out_arg_bo;
    start_prev = root_start_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    int n = 0;
    in_valid_i = 1'b1;
    in_data_bi = d;
    while (!in_ready_o && n < 100) begin tick(); n++; end
    check("push_ready", in_ready_o, 1'b1);
    tick();
  endtask

  task automatic wait_start(output int c);
    int n = 0;
    while (!root_start_o && n < 300) begin tick(); n++; end
    check("start_seen", root_start_o, 1'b1);
    c = cyc;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid_o && n < 300) begin tick(); n++; end
    check("valid_seen", out_valid_o, 1'b1);
  endtask

  task automatic get_result(input logic [7:0] d, input logic [15:0] a);
    wait_valid();
    check("lit_data", out_data_bo, d);
    check("lit_arg", out_arg_bo, a);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  initial begin
    int l;
    int n;
    // Reset for three cycles, then in_ready rises one cycle later.
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("post_reset_ready", in_ready_o, 1'b1);
    check("post_reset_level", level_o, 3'd0);

    // Single operation.
    out_ready_i = 1'b1;
    push(16'd144);
    in_valid_i = 1'b0;
    wait_start(l);
    check("lit_root_x", root_x_bo, 16'd144);
    get_result(8'd12, 16'd144);

    // Burst under backpressure: first operand launches, the rest fill the FIFO.
    push(16'd0); push(16'd225); push(16'd200); push(16'd16); push(16'd100);
    in_valid_i = 1'b0;
    check("full_level", level_o, 3'd4);
    check("full_ready", in_ready_o, 1'b0);
    get_result(8'd0, 16'd0);
    wait_valid();
    repeat (20) tick();
    check("held_data", out_data_bo, 8'd15);
    check("held_no_start", root_start_o, 1'b0);
    get_result(8'd15, 16'd225);
    get_result(8'd14, 16'd200);
    get_result(8'd4, 16'd16);
    get_result(8'd10, 16'd100);

    // Root unit that never finishes.
    repeat (5) tick();
    stub_stuck = 1'b1;
    push(16'd400);
    in_valid_i = 1'b0;
    wait_start(l);
    n = 0;
    while (!err_o && n < 300) begin tick(); n++; end
    check("err_seen", err_o, 1'b1);
    check("err_latency", cyc - l, TOUT + 1);
    repeat (5) tick();
    check("timeout_no_result", out_valid_o, 1'b0);
    stub_stuck = 1'b0;
    repeat (LAT + 3) tick();
    push(16'd49);
    in_valid_i = 1'b0;
    get_result(8'd7, 16'd49);
    check("err_sticky", err_o, 1'b1);

    // Reset while waiting for the unit, with two operands still queued.
    repeat (3) tick();
    push(16'd1000); push(16'd2500); push(16'd65535);
    in_valid_i = 1'b0;
    tick();
    check("pre_reset_level", level_o, 3'd2);
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    check("midreset_level", level_o, 3'd0);
    check("midreset_valid", out_valid_o, 1'b0);
    check("midreset_err", err_o, 1'b0);
    push(16'd81);
    in_valid_i = 1'b0;
    get_result(8'd9, 16'd81);
    push(16'd65535);
    in_valid_i = 1'b0;
    get_result(8'd255, 16'd65535);

    repeat (10) tick();
    check("pend_drained", pend_q.size(), 0);
    check("results_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
